// File: rtl/sequential_divider_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Operand and result handshakes for the sequential divider.
interface sequential_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_value_a;
    logic [WIDTH-1:0] i_value_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_value_quo;
    logic [WIDTH-1:0] o_value_rem;
    logic             o_div_by_zero;

    modport slave (
        input  i_valid, i_value_a, i_value_b, i_ready,
        output o_ready, o_valid, o_value_quo, o_value_rem, o_div_by_zero
    );

    modport master (
        output i_valid, i_value_a, i_value_b, i_ready,
        input  o_ready, o_valid, o_value_quo, o_value_rem, o_div_by_zero
    );
endinterface

// File: rtl/sequential_divider_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quo_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Extra bit: the shifted remainder can exceed WIDTH bits when the divisor is large.
    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        quo_bit  = (shifted >= {1'b0, divisor});
        rem_next = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock.
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    sequential_divider_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] quo_out_reg;
    logic [WIDTH-1:0] rem_out_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] step_rem;
    logic             step_quo_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_reg),
        .dividend_bit (dividend_reg[count_reg]),
        .divisor      (divisor_reg),
        .rem_next     (step_rem),
        .quo_bit      (step_quo_bit)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            valid_reg    <= 1'b0;
            quo_out_reg  <= '0;
            rem_out_reg  <= '0;
            dbz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_valid) begin
                        dividend_reg <= bus.i_value_a;
                        divisor_reg  <= bus.i_value_b;
                        if (bus.i_value_b == '0) begin
                            state_reg   <= DONE;
                            quo_out_reg <= '1;
                            rem_out_reg <= bus.i_value_a;
                            dbz_reg     <= 1'b1;
                        end else begin
                            state_reg <= CALC;
                            count_reg <= CW'(WIDTH - 1);
                            rem_reg   <= '0;
                            quo_reg   <= '0;
                            dbz_reg   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    // Quotient bits arrive MSB first, so shifting in matches quo[count].
                    rem_reg   <= step_rem;
                    quo_reg   <= {quo_reg[WIDTH-2:0], step_quo_bit};
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == '0) begin
                        state_reg   <= DONE;
                        valid_reg   <= 1'b1;
                        quo_out_reg <= {quo_reg[WIDTH-2:0], step_quo_bit};
                        rem_out_reg <= step_rem;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE straight from IDLE; valid follows one clock later.
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                    end else if (bus.i_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_ready       = (state_reg == IDLE);
    assign bus.o_valid       = valid_reg;
    assign bus.o_value_quo   = quo_out_reg;
    assign bus.o_value_rem   = rem_out_reg;
    assign bus.o_div_by_zero = dbz_reg;
endmodule
